// File: rtl/div_vl.sv
// div_vl: variable-latency signed divider, 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Radix-2 restoring division that skips the leading zeros of |dividend|.
// Uses a level start / valid handshake; results hold until start falls.
module div_vl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2*WIDTH-1:0]   dvdnd,
  input  logic [WIDTH-1:0]     dvsor,
  output logic [2*WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]     remd,
  input  logic                 start,
  output logic                 valid,
  output logic                 dbz
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ABS  = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    dvdnd_q, dvdnd_d;
  logic [WIDTH-1:0] dvsor_q, dvsor_d;
  logic             sd_q, sd_d;      // dividend sign
  logic             sv_q, sv_d;      // divisor sign
  logic [DW-1:0]    sreg_q, sreg_d;  // dividend bits out the top, quotient bits in the bottom
  logic [WIDTH-1:0] prem_q, prem_d;  // partial remainder
  logic [WIDTH-1:0] dmag_q, dmag_d;  // |divisor|
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             valid_q, valid_d;
  logic             dbz_q, dbz_d;

  logic [DW-1:0]    abs_dvdnd;
  logic [WIDTH-1:0] abs_dvsor;
  logic [CW-1:0]    nbits;
  logic [CW-1:0]    shamt;
  logic [DW-1:0]    aligned;
  logic [WIDTH:0]   pr;
  logic             ge;

  // Operand magnitudes, bit length of |dividend| and its left-aligned form.
  always_comb begin
    abs_dvdnd = sd_q ? -dvdnd_q : dvdnd_q;
    abs_dvsor = sv_q ? -dvsor_q : dvsor_q;
    nbits     = '0;
    for (int i = 0; i < DW; i++) begin
      if (abs_dvdnd[i]) nbits = CW'(i + 1);
    end
    shamt   = CW'(DW) - nbits;
    aligned = abs_dvdnd << shamt;
  end

  // One restoring step: trial-subtract |divisor| from {prem, next dividend bit}.
  always_comb begin
    pr = {prem_q, sreg_q[DW-1]};
    ge = (pr >= {1'b0, dmag_q});
  end

  // Next-state logic; start low in any busy state abandons the operation.
  always_comb begin
    state_d = state_q;
    dvdnd_d = dvdnd_q;
    dvsor_d = dvsor_q;
    sd_d    = sd_q;
    sv_d    = sv_q;
    sreg_d  = sreg_q;
    prem_d  = prem_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    valid_d = valid_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvdnd_d = dvdnd;
          dvsor_d = dvsor;
          sd_d    = dvdnd[DW-1];
          sv_d    = dvsor[WIDTH-1];
          state_d = ABS;
        end
      end
      ABS: begin
        if (!start) begin
          state_d = IDLE;
        end else if (dvsor_q == '0) begin
          quot_d  = '1;
          remd_d  = dvdnd_q[WIDTH-1:0];
          dbz_d   = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          dmag_d  = abs_dvsor;
          prem_d  = '0;
          sreg_d  = aligned;
          cnt_d   = nbits;
          state_d = (nbits == '0) ? FIX : DIV;
        end
      end
      DIV: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          // True remainder is below |divisor|, so the low WIDTH bits are exact.
          prem_d = ge ? (pr[WIDTH-1:0] - dmag_q) : pr[WIDTH-1:0];
          sreg_d = {sreg_q[DW-2:0], ge};
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          quot_d  = (sd_q ^ sv_q) ? -sreg_q : sreg_q;
          remd_d  = sd_q ? -prem_q : prem_q;
          dbz_d   = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          valid_d = 1'b0;
          dbz_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dvdnd_q <= '0;
      dvsor_q <= '0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      sreg_q  <= '0;
      prem_q  <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvdnd_q <= dvdnd_d;
      dvsor_q <= dvsor_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      sreg_q  <= sreg_d;
      prem_q  <= prem_d;
      dmag_q  <= dmag_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quot  = quot_q;
  assign remd  = remd_q;
  assign valid = valid_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_div_vl.sv
// Self-checking bench for div_vl: directed cases, random cases against an
// arithmetic reference model, handshake abort/hold/reset and multiply round trips.
module tb_div_vl;

  logic        clock;
  logic        reset;
  logic [63:0] dvdnd;
  logic [31:0] dvsor;
  logic [63:0] quot;
  logic [31:0] remd;
  logic        start;
  logic        valid;
  logic        dbz;

  int pass_cnt;
  int total;

  // Last result the DUT should be holding on quot/remd.
  logic [63:0] last_q;
  logic [31:0] last_r;

  div_vl #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .dvdnd (dvdnd),
    .dvsor (dvsor),
    .quot  (quot),
    .remd  (remd),
    .start (start),
    .valid (valid),
    .dbz   (dbz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: truncating signed division, quotient all-ones on divide by zero.
  task automatic model(input logic [63:0] a, input logic [31:0] b, output logic [63:0] q,
                       output logic [31:0] r, output logic z, output int lat);
    longint      sa;
    longint      sb;
    longint      rr;
    logic [63:0] mag;
    int          n;
    sa = longint'(a);
    sb = longint'(signed'(b));
    mag = a[63] ? -a : a;
    n = 0;
    while (mag != 64'd0) begin
      n++;
      mag = mag >> 1;
    end
    if (b == 32'd0) begin
      q = '1;
      r = a[31:0];
      z = 1'b1;
      lat = 1;
    end else begin
      if (sb == -1) begin
        q = -a;
        rr = 0;
      end else begin
        q = 64'(sa / sb);
        rr = sa % sb;
      end
      r = rr[31:0];
      z = 1'b0;
      lat = n + 2;
    end
  endtask

  // Launch one request and wait for valid; start stays high on return.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b, output int cyc);
    @(negedge clock);
    dvdnd = a;
    dvsor = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    // Operands must be ignored once accepted.
    dvdnd = {$urandom, $urandom};
    dvsor = $urandom;
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic drop_start();
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    total++; if (quot !== 64'd0) $display("FAIL reset_quot got %h want 0", quot); else pass_cnt++;
    total++; if (remd !== 32'd0) $display("FAIL reset_remd got %h want 0", remd); else pass_cnt++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else pass_cnt++;
    total++; if (dbz !== 1'b0) $display("FAIL reset_dbz got %b want 0", dbz); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [63:0] ta[7];
    logic [31:0] tb[7];
    logic [63:0] tq[7];
    logic [31:0] tr[7];
    logic        tz[7];
    int          tl[7];
    int          cyc;
    ta = '{64'd100, -64'd100, 64'd100, -64'd100, 64'h1234, 64'd0, 64'h8000_0000_0000_0000};
    tb = '{32'd7, 32'd7, -32'd7, -32'd7, 32'd0, 32'd5, 32'hFFFF_FFFF};
    tq = '{64'd14, 64'hFFFF_FFFF_FFFF_FFF2, -64'd14, 64'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
           64'h8000_0000_0000_0000};
    tr = '{32'd2, 32'hFFFF_FFFE, 32'd2, -32'd2, 32'h0000_1234, 32'd0, 32'd0};
    tz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tl = '{9, 9, 9, 9, 1, 2, 66};
    for (int k = 0; k < 7; k++) begin
      run_op(ta[k], tb[k], cyc);
      total++; if (cyc !== tl[k]) $display("FAIL dir%0d_latency got %0d want %0d", k, cyc, tl[k]);
               else pass_cnt++;
      total++; if (quot !== tq[k]) $display("FAIL dir%0d_quot got %h want %h", k, quot, tq[k]);
               else pass_cnt++;
      total++; if (remd !== tr[k]) $display("FAIL dir%0d_remd got %h want %h", k, remd, tr[k]);
               else pass_cnt++;
      total++; if (dbz !== tz[k]) $display("FAIL dir%0d_dbz got %b want %b", k, dbz, tz[k]);
               else pass_cnt++;
      last_q = tq[k];
      last_r = tr[k];
      drop_start();
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] eq;
    logic [31:0] er;
    logic        ez;
    int          el;
    int          cyc;
    for (int k = 0; k < 20; k++) begin
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = -a;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      if (k == 5) b = 32'd0;
      model(a, b, eq, er, ez, el);
      run_op(a, b, cyc);
      total++; if (cyc !== el) $display("FAIL rnd%0d_latency got %0d want %0d", k, cyc, el);
               else pass_cnt++;
      total++; if (quot !== eq || remd !== er || dbz !== ez)
                 $display("FAIL rnd%0d_result %h/%h got q=%h r=%h z=%b want q=%h r=%h z=%b",
                          k, a, b, quot, remd, dbz, eq, er, ez);
               else pass_cnt++;
      last_q = eq;
      last_r = er;
      drop_start();
    end
  endtask

  task automatic test_abort();
    logic        seen;
    logic [63:0] eq;
    logic [31:0] er;
    logic        ez;
    int          el;
    int          cyc;
    @(negedge clock);
    dvdnd = 64'h0000_00FF_FFFF_FFFF;
    dvsor = 32'd3;
    start = 1'b1;
    @(posedge clock);  // accept
    @(posedge clock);  // ABS
    repeat (4) @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clock);
      #1;
      if (valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL abort_valid got 1 want 0"); else pass_cnt++;
    total++; if (quot !== last_q || remd !== last_r)
               $display("FAIL abort_hold got q=%h r=%h want q=%h r=%h", quot, remd, last_q,
                        last_r);
             else pass_cnt++;
    model(64'h0000_00FF_FFFF_FFFF, 32'd3, eq, er, ez, el);
    run_op(64'h0000_00FF_FFFF_FFFF, 32'd3, cyc);
    total++; if (quot !== eq || remd !== er || cyc !== el)
               $display("FAIL abort_next got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                        quot, remd, cyc, eq, er, el);
             else pass_cnt++;
    last_q = eq;
    last_r = er;
    drop_start();
  endtask

  task automatic test_hold();
    int          cyc;
    int          bad;
    logic [63:0] eq;
    logic [31:0] er;
    logic        ez;
    int          el;
    model(-64'd123456789, 32'd1000, eq, er, ez, el);
    run_op(-64'd123456789, 32'd1000, cyc);
    bad = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (valid !== 1'b1 || quot !== eq || remd !== er || dbz !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL hold_stable got %0d unstable edges want 0", bad);
             else pass_cnt++;
    drop_start();
    total++; if (valid !== 1'b0) $display("FAIL hold_release_valid got %b want 0", valid);
             else pass_cnt++;
    total++; if (quot !== eq || remd !== er)
               $display("FAIL hold_release_keep got q=%h r=%h want q=%h r=%h", quot, remd, eq,
                        er);
             else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    dvdnd = 64'h7FFF_FFFF_FFFF_FFFF;
    dvsor = 32'd9;
    start = 1'b1;
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    total++; if (valid !== 1'b0 || quot !== 64'd0 || remd !== 32'd0)
               $display("FAIL midreset got v=%b q=%h r=%h want 0", valid, quot, remd);
             else pass_cnt++;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_roundtrip();
    int          mlier;
    int          mcand;
    longint      prod;
    logic [63:0] mag;
    int          n;
    int          cyc;
    for (int k = 0; k < 10; k++) begin
      mlier = int'($urandom_range(0, 32'h0FFF_FFFE));
      mcand = int'($urandom_range(1, 32'h0FFF_FFFE));
      if ($urandom_range(0, 1) == 1) mlier = -mlier;
      if ($urandom_range(0, 1) == 1) mcand = -mcand;
      prod = longint'(mlier) * longint'(mcand);
      mag = (prod < 0) ? 64'(-prod) : 64'(prod);
      n = 0;
      while (mag != 64'd0) begin
        n++;
        mag = mag >> 1;
      end
      run_op(64'(prod), 32'(mcand), cyc);
      $display("roundtrip %0d: %0d*%0d took %0d cycles", k, mlier, mcand, cyc);
      total++; if (quot !== 64'(longint'(mlier)) || remd !== 32'd0)
                 $display("FAIL rt%0d_result got q=%h r=%h want q=%h r=0", k, quot, remd,
                          64'(longint'(mlier)));
               else pass_cnt++;
      total++; if (cyc !== n + 2) $display("FAIL rt%0d_latency got %0d want %0d", k, cyc, n + 2);
               else pass_cnt++;
      drop_start();
    end
  endtask

  initial begin
    pass_cnt = 0;
    total = 0;
    last_q = '0;
    last_r = '0;
    reset = 1'b0;
    start = 1'b0;
    dvdnd = '0;
    dvsor = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b1;
    test_directed();
    test_random();
    test_abort();
    test_hold();
    test_reset_mid();
    test_reset();
    test_roundtrip();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/div_vl.md
Name: div_vl

Overview:
- Variable-latency signed divider, 64-bit dividend by 32-bit divisor. It is the inverse unit of the variable-latency multiplier.
- Uses the same level-start / valid handshake as the multiplier, so one bench can drive both and round-trip results (product / multiplicand == multiplier).
- Radix-2 restoring division. Iterations are skipped over the leading zeros of |dividend|, so latency depends on the operand value.

Parameters:
- WIDTH, 32, divisor/remainder width; dividend/quotient width is 2*WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- dvdnd  input  2*WIDTH  signed dividend, sampled when start is accepted.
- dvsor  input  WIDTH  signed divisor, sampled when start is accepted.
- quot  output  2*WIDTH  signed quotient.
- remd  output  WIDTH  signed remainder.
- start  input  1  level request; held high until valid is seen.
- valid  output  1  result ready; held until start falls.
- dbz  output  1  divide-by-zero flag, qualified by valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; quot=0, remd=0, valid=0, dbz=0.
  - All internal registers cleared. An operation in flight is abandoned.
- States: IDLE, ABS, DIV, FIX, DONE.
- IDLE:
  - start=1 at edge E0: latch dvdnd/dvsor and both sign bits -> ABS. quot/remd are not modified.
- ABS (edge E0+1):
  - Form magnitudes |dvdnd| (2W bits, unsigned) and |dvsor|.
  - n = bit length of |dvdnd| (0..2W).
  - dvsor==0:
    - quot = all ones, remd = dvdnd[W-1:0], dbz=1, valid=1 -> DONE.
    - Valid is visible after E0+1.
  - n==0: go to FIX.
  - Otherwise: left-align |dvdnd| by 2W-n in the shift register, iteration counter=n -> DIV.
- DIV (one quotient bit per edge):
  - Partial remainder (W+1 bits) = {prem, next dividend bit}.
  - If ≥ |dvsor|: subtract and shift in 1; else shift in 0.
  - Counter decrements; on the last iteration -> FIX.
- FIX (one edge):
  - quot negated if dividend sign != divisor sign.
  - remd takes the sign of the dividend (truncation toward zero).
  - dbz=0, valid=1 -> DONE.
- Latency: valid rises after edge E0+n+2. Range: 2 edges (dividend 0) to 2W+2 = 66 edges (|dvdnd|=2^63).
- DONE:
  - quot/remd/dbz/valid hold while start=1.
  - start=0 at an edge -> valid=0, dbz=0, IDLE. quot/remd keep their last value.
- Abort: start=0 while in ABS/DIV/FIX -> IDLE at that edge. valid stays 0; quot/remd are unchanged.
- Back-to-back requests: a new request needs at least one edge with start=0. start must be low for ≥1 edge to launch the next operation, even if start is still high when DONE is left.
- Overflow: dvdnd=-2^(2W-1), dvsor=-1 -> quot wraps to -2^(2W-1), remd=0, no flag.
- Invariant (dbz=0): dvdnd == quot*dvsor + remd; |remd| < |dvsor|; remd is 0 or has the sign of dvdnd.
- Operand changes after acceptance have no effect.

Test Plan:
- 100 / 7: quot=14, remd=2, dbz=0. n=7, so valid rises 9 edges after start is sampled.
- Sign combinations:
  - -100 / 7 -> quot=0xFFFF_FFFF_FFFF_FFF2, remd=0xFFFF_FFFE.
  - 100 / -7 -> quot=-14, remd=2.
  - -100 / -7 -> quot=14, remd=-2.
- Divide by zero and zero dividend:
  - dvdnd=0x1234, dvsor=0 -> quot=0xFFFF_FFFF_FFFF_FFFF, remd=0x0000_1234, dbz=1, valid after 1 edge.
  - dvdnd=0, dvsor=5 -> quot=0, remd=0, valid after 2 edges.
- Worst case and overflow: 0x8000_0000_0000_0000 / -1 -> quot=0x8000_0000_0000_0000, remd=0, valid after 66 edges.
- Handshake:
  - Drop start after 4 DIV edges -> valid never rises, quot/remd unchanged. Next request (after start low ≥1 edge) returns the correct result.
  - Hold start 10 edges past valid -> outputs stable. start low -> valid=0 on the next edge.
  - Pull reset low mid-DIV -> valid/quot/remd=0 immediately, without a clock edge.
- Round trip: 10 random pairs mlier, mcand (|x| < 0x0FFF_FFFF, nonzero mcand). Divide mlier*mcand by mcand -> quot == sign-extended mlier, remd=0. Log cycles per operation and check each equals n+2.
